// File: rtl/gfau.sv
// Prime-field GF(p) arithmetic unit: modular add, sub, multiply (MSB-first interleaved
// reduction) and divide (binary extended Euclid), one operation at a time.
module gfau #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] prime,
   input  logic [1:0]       operation_select,
   input  logic             done_from_control,
   output logic [WIDTH-1:0] result,
   output logic             done_to_control,
   output logic             done_add,
   output logic             done_sub,
   output logic             done_mult,
   output logic             done_div,
   output logic [WIDTH-1:0] div_out,
   output logic [WIDTH:0]   R
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   state_t           r_state;
   op_t              r_op;
   logic             r_first;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_p;
   logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2;
   logic [WIDTH:0]   r_r;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_result;
   logic             r_done, r_done_add, r_done_sub, r_done_mult, r_done_div;

   // (x - y) mod p for x, y < p; wrap-around in WIDTH bits lands back in [0, p).
   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, y, p);
      return (x >= y) ? x - y : x - y + p;
   endfunction

   // x / 2 mod p: odd x is made even by adding p before the shift.
   function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x, p);
      logic [WIDTH:0] t;
      t = x[0] ? {1'b0, x} + {1'b0, p} : {1'b0, x};
      return WIDTH'(t >> 1);
   endfunction

   logic [WIDTH:0]   w_p33, w_sum, w_r2, w_r2m, w_rpa, w_rnext;
   logic [WIDTH-1:0] w_add;

   assign w_p33   = {1'b0, r_p};
   assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
   assign w_add   = (w_sum >= w_p33) ? WIDTH'(w_sum - w_p33) : WIDTH'(w_sum);
   assign w_r2    = {r_r[WIDTH-1:0], 1'b0};
   assign w_r2m   = (w_r2 >= w_p33) ? w_r2 - w_p33 : w_r2;
   assign w_rpa   = w_r2m + {1'b0, r_a};
   assign w_rnext = r_b[WIDTH-1] ? ((w_rpa >= w_p33) ? w_rpa - w_p33 : w_rpa) : w_r2m;

   // NOTE: every register here is state, so it is assigned with <= only; the
   // reset branch clears all of it so nothing survives an abandoned operation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_op        <= OP_ADD;
         r_first     <= 1'b0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_p         <= '0;
         r_u         <= '0;
         r_v         <= '0;
         r_x1        <= '0;
         r_x2        <= '0;
         r_r         <= '0;
         r_res       <= '0;
         r_result    <= '0;
         r_done      <= 1'b0;
         r_done_add  <= 1'b0;
         r_done_sub  <= 1'b0;
         r_done_mult <= 1'b0;
         r_done_div  <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_done_add  <= 1'b0;
         r_done_sub  <= 1'b0;
         r_done_mult <= 1'b0;
         r_done_div  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (done_from_control) begin
                  r_a     <= in_0;
                  r_b     <= in_1;
                  r_p     <= prime;
                  r_op    <= op_t'(operation_select);
                  r_first <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_first <= 1'b0;
               case (r_op)
                  OP_ADD: begin
                     r_res   <= w_add;
                     r_state <= S_FIN;
                  end
                  OP_SUB: begin
                     r_res   <= sub_mod(r_a, r_b, r_p);
                     r_state <= S_FIN;
                  end
                  OP_MUL: begin
                     if (r_first) begin
                        r_r   <= '0;
                        r_cnt <= '0;
                     end else begin
                        r_r   <= w_rnext;
                        r_res <= w_rnext[WIDTH-1:0];
                        r_b   <= r_b << 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BIT) r_state <= S_FIN;
                     end
                  end
                  OP_DIV: begin
                     if (r_first) begin
                        if (r_b == '0) begin
                           r_res   <= '0;
                           r_state <= S_FIN;
                        end else begin
                           r_u  <= r_b;
                           r_v  <= r_p;
                           r_x1 <= r_a;
                           r_x2 <= '0;
                        end
                     end else if (r_u == WIDTH'(1)) begin
                        r_res   <= r_x1;
                        r_state <= S_FIN;
                     end else if (r_v == WIDTH'(1)) begin
                        r_res   <= r_x2;
                        r_state <= S_FIN;
                     end else if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_x1 <= half(r_x1, r_p);
                     end else if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_x2 <= half(r_x2, r_p);
                     end else if (r_u >= r_v) begin
                        r_u  <= r_u - r_v;
                        r_x1 <= sub_mod(r_x1, r_x2, r_p);
                     end else begin
                        r_v  <= r_v - r_u;
                        r_x2 <= sub_mod(r_x2, r_x1, r_p);
                     end
                  end
                  default: r_state <= S_FIN;
               endcase
            end
            S_FIN: begin
               r_result    <= r_res;
               r_done      <= 1'b1;
               r_done_add  <= (r_op == OP_ADD);
               r_done_sub  <= (r_op == OP_SUB);
               r_done_mult <= (r_op == OP_MUL);
               r_done_div  <= (r_op == OP_DIV);
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign result          = r_result;
   assign done_to_control = r_done;
   assign done_add        = r_done_add;
   assign done_sub        = r_done_sub;
   assign done_mult       = r_done_mult;
   assign done_div        = r_done_div;
   assign div_out         = r_x1;
   assign R               = r_r;

endmodule

// File: tb/tb_gfau.sv
// Self-checking bench for gfau: directed cases, protocol cases and randomised ops
// against an arithmetic reference model (Fermat inverse for divide).
module tb_gfau;

   localparam int W = 32;
   localparam int TIMEOUT = 200;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [W-1:0]  in_0, in_1, prime;
   logic [1:0]    operation_select;
   logic          done_from_control;
   logic [W-1:0]  result;
   logic          done_to_control, done_add, done_sub, done_mult, done_div;
   logic [W-1:0]  div_out;
   logic [W:0]    R;

   int n_pass  = 0;
   int n_total = 0;

   gfau #(.WIDTH(W)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .in_0              (in_0),
      .in_1              (in_1),
      .prime             (prime),
      .operation_select  (operation_select),
      .done_from_control (done_from_control),
      .result            (result),
      .done_to_control   (done_to_control),
      .done_add          (done_add),
      .done_sub          (done_sub),
      .done_mult         (done_mult),
      .done_div          (done_div),
      .div_out           (div_out),
      .R                 (R)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [4:0] flags_now();
      return {done_to_control, done_add, done_sub, done_mult, done_div};
   endfunction

   function automatic logic [4:0] flags_exp(input logic [1:0] op);
      return {1'b1, op == 2'd0, op == 2'd1, op == 2'd2, op == 2'd3};
   endfunction

   function automatic longint unsigned pow_mod(input longint unsigned b, e, p);
      longint unsigned acc = 1;
      longint unsigned base = b % p;
      while (e != 0) begin
         if (e[0]) acc = (acc * base) % p;
         base = (base * base) % p;
         e = e >> 1;
      end
      return acc;
   endfunction

   function automatic logic [W-1:0] model(input logic [1:0] op, input longint unsigned a, b, p);
      case (op)
         2'd0:    return W'((a + b) % p);
         2'd1:    return W'((a + p - b) % p);
         2'd2:    return W'((a * b) % p);
         default: return (b == 0) ? '0 : W'((a * pow_mod(b, p - 2, p)) % p);
      endcase
   endfunction

   function automatic bit is_prime(input longint unsigned n);
      for (longint unsigned d = 3; d * d <= n; d += 2)
         if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic longint unsigned rand_prime();
      longint unsigned n;
      n = 64'h8000_0000 + longint'($urandom % 32'h7000_0000);
      n = n | 64'd1;
      while (!is_prime(n)) n += 2;
      return n;
   endfunction

   // Launch one op and wait (bounded) for done; lat counts edges after the sampling edge.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, p, output int lat);
      @(negedge i_clk);
      operation_select  = op;
      in_0              = a;
      in_1              = b;
      prime             = p;
      done_from_control = 1'b1;
      @(posedge i_clk); #1;
      done_from_control = 1'b0;
      lat = 0;
      while (done_to_control !== 1'b1 && lat < TIMEOUT) begin
         @(posedge i_clk); #1;
         lat++;
      end
   endtask

   task automatic verify(input string tag, input logic [1:0] op, input logic [W-1:0] exp);
      check({tag, "_result"}, result, exp);
      check({tag, "_flags"}, flags_now(), flags_exp(op));
      @(posedge i_clk); #1;
      check({tag, "_pulse_end"}, flags_now(), 5'b0);
   endtask

   initial begin
      int lat;
      int seen;
      longint unsigned pool[6];
      logic [W-1:0] ra, rb, rp;

      i_rst = 1'b1;
      in_0 = '0; in_1 = '0; prime = '0;
      operation_select = 2'd0;
      done_from_control = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_result", result, '0);
      check("rst_div_out", div_out, '0);
      check("rst_R", R, '0);
      check("rst_flags", flags_now(), 5'b0);
      i_rst = 1'b0;

      run_op(2'd0, 32'd20, 32'd5, 32'd23, lat);
      check("add1_lat", lat, 2);
      verify("add1", 2'd0, 32'd2);
      run_op(2'd0, 32'd3, 32'd4, 32'd23, lat);
      verify("add2", 2'd0, 32'd7);

      run_op(2'd1, 32'd3, 32'd7, 32'd23, lat);
      check("sub1_lat", lat, 2);
      verify("sub1", 2'd1, 32'd19);
      run_op(2'd1, 32'd7, 32'd7, 32'd23, lat);
      verify("sub2", 2'd1, 32'd0);

      run_op(2'd2, 32'd7, 32'd9, 32'd23, lat);
      check("mul1_lat", lat, 34);
      verify("mul1", 2'd2, 32'd17);
      run_op(2'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, lat);
      check("mul2_lat", lat, 34);
      verify("mul2", 2'd2, 32'd1);

      run_op(2'd3, 32'd6, 32'd3, 32'd23, lat);
      check("div1_lat_le66", lat <= 66, 1'b1);
      verify("div1", 2'd3, 32'd2);
      run_op(2'd3, 32'd1, 32'd2, 32'd23, lat);
      check("div2_lat_le66", lat <= 66, 1'b1);
      verify("div2", 2'd3, 32'd12);
      run_op(2'd3, 32'd5, 32'd0, 32'd23, lat);
      check("div0_lat", lat, 2);
      verify("div0", 2'd3, 32'd0);

      // Start held high: inputs changed while busy must not disturb the running op.
      @(negedge i_clk);
      operation_select = 2'd0; in_0 = 32'd20; in_1 = 32'd5; prime = 32'd23;
      done_from_control = 1'b1;
      @(posedge i_clk); #1;
      operation_select = 2'd1; in_0 = 32'd3; in_1 = 32'd7;
      lat = 0;
      while (done_to_control !== 1'b1 && lat < TIMEOUT) begin
         @(posedge i_clk); #1;
         lat++;
      end
      check("b2b_first_lat", lat, 2);
      check("b2b_first_result", result, 32'd2);
      check("b2b_first_flags", flags_now(), flags_exp(2'd0));
      lat = 0;
      do begin
         @(posedge i_clk); #1;
         lat++;
      end while (done_to_control !== 1'b1 && lat < TIMEOUT);
      done_from_control = 1'b0;
      check("b2b_second_gap", lat, 3);
      check("b2b_second_result", result, 32'd19);
      check("b2b_second_flags", flags_now(), flags_exp(2'd1));

      // Reset in the middle of a multiply abandons it silently.
      @(negedge i_clk);
      operation_select = 2'd2; in_0 = 32'd7; in_1 = 32'd9; prime = 32'd23;
      done_from_control = 1'b1;
      @(posedge i_clk); #1;
      done_from_control = 1'b0;
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      check("midrst_result", result, '0);
      check("midrst_R", R, '0);
      check("midrst_div_out", div_out, '0);
      check("midrst_flags", flags_now(), 5'b0);
      seen = 0;
      repeat (40) begin
         @(posedge i_clk); #1;
         if (done_to_control === 1'b1) seen++;
      end
      check("midrst_no_done", seen, 0);
      run_op(2'd2, 32'd7, 32'd9, 32'd23, lat);
      check("postrst_mul_lat", lat, 34);
      verify("postrst_mul", 2'd2, 32'd17);

      foreach (pool[i]) pool[i] = rand_prime();
      for (int op = 0; op < 4; op++) begin
         for (int i = 0; i < 10; i++) begin
            rp = W'(pool[$urandom % 6]);
            ra = W'($urandom % rp);
            rb = W'($urandom % rp);
            run_op(2'(op), ra, rb, rp, lat);
            if (op < 2)       check("rand_lat", lat, 2);
            else if (op == 2) check("rand_lat", lat, 34);
            else              check("rand_div_bounded", lat < TIMEOUT, 1'b1);
            verify($sformatf("rand_op%0d_%0d", op, i), 2'(op), model(2'(op), ra, rb, rp));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
